// File: rtl/snes_joypad_reader.sv
// SNES controller poller: drives latch/clock, shifts in 16 serial button bits
// and publishes each complete frame as an active-low parallel word.
module snes_joypad_reader #(
  parameter int unsigned HALF_PERIOD = 256,
  parameter int unsigned POLL_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        joy_latch,
  output logic        joy_clk,
  input  logic        joy_data,
  output logic [15:0] joypad_state,
  output logic        state_valid
);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    CLK_LO,
    CLK_HI,
    DONE
  } state_t;

  localparam logic [31:0] H_LAST     = 32'(HALF_PERIOD - 1);
  localparam logic [31:0] LATCH_LAST = 32'(2 * HALF_PERIOD - 1);
  localparam logic [31:0] POLL_LAST  = 32'(POLL_CYCLES);

  state_t      state;
  logic [31:0] cnt;
  logic [4:0]  bit_idx;
  logic [15:0] sr;
  logic        data_meta;
  logic        data_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      sr           <= '1;
      data_meta    <= 1'b1;
      data_sync    <= 1'b1;
      joy_latch    <= 1'b0;
      joy_clk      <= 1'b1;
      joypad_state <= '1;
      state_valid  <= 1'b0;
    end else begin
      data_meta   <= joy_data;
      data_sync   <= data_meta;
      state_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Counter parks at terminal count until enable is seen.
          if (cnt == POLL_LAST) begin
            if (enable) begin
              state     <= LATCH;
              cnt       <= '0;
              joy_latch <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        LATCH: begin
          if (cnt == LATCH_LAST) begin
            state     <= GAP;
            cnt       <= '0;
            joy_latch <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
          if (cnt == H_LAST) begin
            sr[0]   <= data_sync;
            bit_idx <= 5'd1;
            state   <= CLK_LO;
            cnt     <= '0;
            joy_clk <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        CLK_LO: begin
          if (cnt == H_LAST) begin
            state   <= CLK_HI;
            cnt     <= '0;
            joy_clk <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        CLK_HI: begin
          if (cnt == H_LAST) begin
            cnt <= '0;
            if (bit_idx <= 5'd15) sr[bit_idx[3:0]] <= data_sync;
            // The 16th clock pulse only returns the pad to idle; nothing sampled.
            if (bit_idx == 5'd16) begin
              state        <= DONE;
              joypad_state <= sr;
              state_valid  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 5'd1;
              state   <= CLK_LO;
              joy_clk <= 1'b0;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snes_joypad_reader.sv
// Bench for snes_joypad_reader: behavioural pad, frame-timing monitor and
// table/random frame patterns checked against a word-level expectation model.
module tb_snes_joypad_reader;

  localparam int H         = 4;
  localparam int POLL      = 20;
  localparam int PERIOD    = 35 * H + POLL + 2;
  localparam int DONE_LAT  = 35 * H;
  localparam int NVEC      = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        joy_latch;
  logic        joy_clk;
  logic        joy_data;
  logic [15:0] joypad_state;
  logic        state_valid;

  snes_joypad_reader #(.HALF_PERIOD(H), .POLL_CYCLES(POLL)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .joy_latch   (joy_latch),
    .joy_clk     (joy_clk),
    .joy_data    (joy_data),
    .joypad_state(joypad_state),
    .state_valid (state_valid)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Pad model: holds the first bit while latched, advances one bit per
  // rising edge of joy_clk, and reads 1 (pull-up) when absent or exhausted.
  logic [15:0] pad_word    = 16'hF0A5;
  bit          pad_present = 1'b1;
  logic [15:0] pad_cur     = 16'hFFFF;
  int          pad_idx     = 16;
  logic        pad_prev_clk = 1'b1;

  always @(negedge clock) begin
    if (joy_latch) begin
      pad_idx = 0;
      pad_cur = pad_word;
    end else if (joy_clk && !pad_prev_clk) begin
      pad_idx++;
    end
    pad_prev_clk = joy_clk;
  end

  assign joy_data = (!pad_present || pad_idx >= 16) ? 1'b1 : pad_cur[pad_idx];

  function automatic logic [15:0] expected_word(input logic [15:0] pad, input bit present);
    logic [15:0] w;
    w = 16'hFFFF;
    if (present)
      for (int i = 0; i < 16; i++) w[i] = pad[i];
    return w;
  endfunction

  // Frame monitor, sampled on the falling edge.
  logic        m_latch = 1'b0;
  logic        m_clk = 1'b1;
  logic        m_valid = 1'b0;
  int          latch_hi = 0;
  int          clk_lo = 0;
  int          pulses = 0;
  int          rise_cyc = -1;
  int          valid_cyc = -1;
  int          n_rises = 0;
  int          n_valid = 0;
  logic [15:0] exp_word = 16'hFFFF;
  logic [15:0] prev_state = 16'hFFFF;

  always @(negedge clock) begin
    if (!reset) begin
      m_latch = 1'b0; m_clk = 1'b1; m_valid = 1'b0;
      latch_hi = 0; clk_lo = 0; pulses = 0;
      prev_state = 16'hFFFF;
    end else begin
      if (joy_latch) latch_hi++;
      if (joy_latch && !m_latch) begin
        rise_cyc = cyc;
        n_rises++;
        pulses = 0;
        exp_word = expected_word(pad_word, pad_present);
      end
      if (!joy_latch && m_latch) begin
        check("latch_width", latch_hi, 2 * H);
        latch_hi = 0;
      end
      if (!joy_clk) clk_lo++;
      if (joy_clk && !m_clk) begin
        check("clk_low_width", clk_lo, H);
        clk_lo = 0;
        pulses++;
      end
      if (state_valid && !m_valid) begin
        check("clk_pulse_count", pulses, 16);
        check("done_latency", cyc - rise_cyc, DONE_LAT);
        check("frame_value", int'(joypad_state), int'(exp_word));
        valid_cyc = cyc;
        n_valid++;
      end
      if (m_valid) check("valid_one_cycle", int'(state_valid), 0);
      if (joypad_state !== prev_state && !state_valid)
        check("state_stable", int'(joypad_state), int'(prev_state));
      prev_state = joypad_state;
      m_latch = joy_latch; m_clk = joy_clk; m_valid = state_valid;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_rise(input int limit);
    int start;
    int seen;
    start = n_rises;
    seen = 0;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (n_rises != start) begin seen = 1; break; end
    end
    check("latch_rise_timeout", seen, 1);
  endtask

  task automatic wait_valid(input int limit);
    int start;
    int seen;
    start = n_valid;
    seen = 0;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (n_valid != start) begin seen = 1; break; end
    end
    check("valid_timeout", seen, 1);
  endtask

  typedef struct {
    logic [15:0] pad;
    bit          present;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    int rel_cyc;
    int prev_valid;
    int saved;

    vecs[0] = '{16'hFFFF, 1'b0, 16'hFFFF};
    vecs[1] = '{16'h1234, 1'b0, 16'hFFFF};
    vecs[2] = '{16'hFFFE, 1'b1, 16'hFFFE};
    vecs[3] = '{16'hFFFD, 1'b1, 16'hFFFD};
    vecs[4] = '{16'h7FFF, 1'b1, 16'h7FFF};
    vecs[5] = '{16'h0000, 1'b1, 16'h0000};
    for (int i = 6; i < NVEC; i++) begin
      vecs[i].pad     = 16'($urandom);
      vecs[i].present = 1'b1;
      vecs[i].exp     = expected_word(vecs[i].pad, 1'b1);
    end

    // Reset state and first-latch latency.
    enable = 1'b1;
    pad_word = 16'hF0A5;
    repeat (3) tick();
    check("rst_latch", int'(joy_latch), 0);
    check("rst_clk", int'(joy_clk), 1);
    check("rst_state", int'(joypad_state), 16'hFFFF);
    check("rst_valid", int'(state_valid), 0);
    reset = 1'b1;
    rel_cyc = cyc;
    wait_rise(40);
    check("first_latch_delay", rise_cyc - rel_cyc, POLL + 1);
    wait_valid(200);
    check("f0a5_state", int'(joypad_state), 16'hF0A5);

    // Table of patterns, one per frame, with frame-to-frame spacing.
    prev_valid = valid_cyc;
    for (int i = 0; i < NVEC; i++) begin
      pad_word = vecs[i].pad;
      pad_present = vecs[i].present;
      wait_valid(PERIOD + 10);
      check("table_state", int'(joypad_state), int'(vecs[i].exp));
      check("frame_spacing", valid_cyc - prev_valid, PERIOD);
      prev_valid = valid_cyc;
    end

    // enable dropped during the 5th clock pulse.
    pad_present = 1'b1;
    pad_word = 16'hA5C3;
    wait_rise(PERIOD);
    for (int k = 0; k < 200; k++) begin
      if (pulses == 4 && !joy_clk) break;
      tick();
    end
    check("fifth_pulse_reached", pulses, 4);
    enable = 1'b0;
    wait_valid(200);
    check("disabled_frame_state", int'(joypad_state), 16'hA5C3);
    saved = n_rises;
    repeat (80) tick();
    check("no_latch_while_disabled", n_rises, saved);
    check("latch_low_before_enable", int'(joy_latch), 0);
    pad_word = 16'hF0A5;
    enable = 1'b1;
    tick();
    check("latch_one_after_enable", int'(joy_latch), 1);
    wait_valid(200);
    check("reenable_state", int'(joypad_state), 16'hF0A5);

    // Reset during bit 9, then a new pad pattern.
    wait_rise(PERIOD);
    for (int k = 0; k < 200; k++) begin
      if (pulses == 9 && !joy_clk) break;
      tick();
    end
    check("bit9_reached", pulses, 9);
    pad_word = 16'h0FFE;
    reset = 1'b0;
    #1;
    check("abort_latch", int'(joy_latch), 0);
    check("abort_clk", int'(joy_clk), 1);
    check("abort_state", int'(joypad_state), 16'hFFFF);
    check("abort_valid", int'(state_valid), 0);
    repeat (3) tick();
    reset = 1'b1;
    rel_cyc = cyc;
    wait_rise(40);
    check("post_reset_latch_delay", rise_cyc - rel_cyc, POLL + 1);
    wait_valid(200);
    check("post_reset_state", int'(joypad_state), 16'h0FFE);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
